// File: rtl/ni_flit_injector_pkg.sv
// ni_flit_injector_pkg
//   Shared definitions for the NI flit injector: flit field offsets,
//   header field offsets, width helpers and the injector FSM state type.
//   Flit layout, MSB first: hdr_flag, tail_flag, V-bit one-hot VC, payload.
package ni_flit_injector_pkg;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int log2c(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of the message-class field: max(1, log2(C)).
    function automatic int cw_f(input int c);
        return log2c(c);
    endfunction

    function automatic int flit_w(input int v, input int fpay);
        return 2 + v + fpay;
    endfunction

    function automatic int hdr_bit(input int v, input int fpay);
        return flit_w(v, fpay) - 1;
    endfunction

    function automatic int tail_bit(input int v, input int fpay);
        return flit_w(v, fpay) - 2;
    endfunction

    function automatic int vc_lsb(input int fpay);
        return fpay;
    endfunction

    // Header payload: src at bit 0, dest above it, class above dest.
    localparam int HDR_SRC_LSB = 0;

    function automatic int hdr_dest_lsb(input int eaw);
        return eaw;
    endfunction

    function automatic int hdr_class_lsb(input int eaw);
        return 2 * eaw;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } inj_state_t;

endpackage

// File: rtl/ni_flit_injector_credit.sv
// ni_vc_credit_cnt
//   V downstream-credit counters, one per VC, each reset to B.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     dec        : per-VC flit sent this cycle (decrement)
//     inc        : per-VC credit returned this cycle (increment)
//     avail      : per-VC "credit left once this cycle's send is counted"
module ni_vc_credit_cnt
    import ni_flit_injector_pkg::*;
#(
    parameter int V = 4,
    parameter int B = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [V-1:0] dec,
    input  logic [V-1:0] inc,
    output logic [V-1:0] avail
);
    localparam int CNTw = log2c(B + 1);

    for (genvar gi = 0; gi < V; gi++) begin : g_vc
        logic [CNTw-1:0] cnt;

        // Send and credit together cancel out; otherwise saturate at 0..B.
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                cnt <= CNTw'(B);
            else if (inc[gi] && !dec[gi])
                cnt <= (cnt == CNTw'(B)) ? cnt : cnt + CNTw'(1);
            else if (dec[gi] && !inc[gi])
                cnt <= (cnt == '0) ? cnt : cnt - CNTw'(1);
        end

        // A flit already on the wire this cycle still owns one credit.
        assign avail[gi] = dec[gi] ? (cnt > CNTw'(1)) : (cnt != '0);

`ifndef SYNTHESIS
        always @(posedge clk) begin
            if (!reset && inc[gi] && !dec[gi] && cnt == CNTw'(B))
                $display("%0t ni_vc_credit_cnt: credit overflow on vc %0d", $time, gi);
            if (!reset && dec[gi] && !inc[gi] && cnt == '0)
                $display("%0t ni_vc_credit_cnt: credit underflow on vc %0d", $time, gi);
        end
`endif
    end

endmodule

// File: rtl/ni_flit_injector.sv
// ni_flit_injector
//   NI transmitter feeding one router input port. Splits core packet
//   requests into header/body/tail flits, picks a VC per packet
//   (class-restricted round robin among VCs with credit) and tracks credits.
//   Ports:
//     clk, reset                 : clock, asynchronous active-high reset
//     src_e_addr                 : own endpoint address (static)
//     pck_req/dest/class/size    : packet request; pck_ack accepts it (comb)
//     data_in/data_valid         : body payload; data_ready consumes it (comb)
//     flit_out/flit_out_we       : registered flit to router
//     credit_in                  : one-hot per-VC credit return
//     busy                       : packet body in progress
module ni_flit_injector
    import ni_flit_injector_pkg::*;
#(
    parameter int V             = 4,
    parameter int B             = 4,
    parameter int C             = 2,
    parameter int Fpay          = 32,
    parameter int EAw           = 6,
    parameter int CVw           = (C == 0) ? V : C * V,
    parameter logic [CVw-1:0] CLASS_SETTING = {CVw{1'b1}},
    parameter int MIN_PCK_SIZE  = 2,
    parameter int PCK_SIZEw     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [EAw-1:0]                src_e_addr,
    input  logic                          pck_req,
    input  logic [EAw-1:0]                pck_dest,
    input  logic [cw_f(C)-1:0]            pck_class,
    input  logic [PCK_SIZEw-1:0]          pck_size,
    output logic                          pck_ack,
    input  logic [Fpay-1:0]               data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic [flit_w(V, Fpay)-1:0]    flit_out,
    output logic                          flit_out_we,
    input  logic [V-1:0]                  credit_in,
    output logic                          busy
);
    localparam int Cw  = cw_f(C);
    localparam int VCw = log2c(V);
    localparam int NC  = (C == 0) ? 1 : C;

    inj_state_t           state;
    logic [VCw-1:0]       rr_ptr, win;
    logic [V-1:0]         vc_q, avail, class_vcs, elig, grant, dec;
    logic [PCK_SIZEw-1:0] rem_q, size_eff;
    logic [Fpay-1:0]      hdr_pay;
    logic                 found, beat;

    ni_vc_credit_cnt #(.V(V), .B(B)) u_credit (
        .clk   (clk),
        .reset (reset),
        .dec   (dec),
        .inc   (credit_in),
        .avail (avail)
    );

    assign dec = flit_out_we ? flit_out[vc_lsb(Fpay) +: V] : '0;

    always_comb begin
        class_vcs = '0;
        for (int c = 0; c < NC; c++)
            if (C == 0 || int'(pck_class) == c)
                class_vcs = CLASS_SETTING[c*V +: V];
    end

    assign elig = class_vcs & avail;

    // Round robin: first eligible VC at or after rr_ptr.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < V; i++) begin
            idx = (int'(rr_ptr) + i) % V;
            if (!found && elig[idx]) begin
                grant[idx] = 1'b1;
                win        = VCw'(idx);
                found      = 1'b1;
            end
        end
    end

    // Undersized (or zero) requests are padded up to the minimum size.
    assign size_eff = (pck_size < PCK_SIZEw'(MIN_PCK_SIZE)) ? PCK_SIZEw'(MIN_PCK_SIZE) : pck_size;

    always_comb begin
        hdr_pay = '0;
        hdr_pay[HDR_SRC_LSB +: EAw]        = src_e_addr;
        hdr_pay[hdr_dest_lsb(EAw) +: EAw]  = pck_dest;
        hdr_pay[hdr_class_lsb(EAw) +: Cw]  = pck_class;
    end

    assign pck_ack    = !reset && state == IDLE && pck_req && found;
    assign data_ready = state == BODY && |(vc_q & avail);
    assign beat       = data_ready && data_valid;
    assign busy       = state == BODY;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            vc_q        <= '0;
            rem_q       <= '0;
            flit_out    <= '0;
            flit_out_we <= 1'b0;
        end else begin
            flit_out_we <= 1'b0;
            case (state)
                IDLE: if (pck_ack) begin
                    flit_out    <= {1'b1, size_eff == PCK_SIZEw'(1), grant, hdr_pay};
                    flit_out_we <= 1'b1;
                    vc_q        <= grant;
                    rem_q       <= size_eff - PCK_SIZEw'(1);
                    rr_ptr      <= VCw'((int'(win) + 1) % V);
                    if (size_eff != PCK_SIZEw'(1))
                        state <= BODY;
                end
                BODY: if (beat) begin
                    flit_out    <= {1'b0, rem_q == PCK_SIZEw'(1), vc_q, data_in};
                    flit_out_we <= 1'b1;
                    rem_q       <= rem_q - PCK_SIZEw'(1);
                    if (rem_q == PCK_SIZEw'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk)
        if (!reset && pck_ack && pck_size < PCK_SIZEw'(MIN_PCK_SIZE))
            $display("%0t ni_flit_injector: warning, size %0d padded to %0d",
                     $time, pck_size, MIN_PCK_SIZE);
`endif

endmodule

// File: tb/tb_ni_flit_injector.sv
// Scoreboard bench for ni_flit_injector. Stimulus tasks push the expected
// flit (and the cycle it must appear in) when a request or beat is accepted;
// a negedge monitor pops and compares whenever flit_out_we is high.
module tb_ni_flit_injector;
    import ni_flit_injector_pkg::*;

    localparam int V = 4, B = 4, C = 2, Fpay = 32, EAw = 6, PSw = 8;
    localparam int Fw = flit_w(V, Fpay);
    localparam logic [7:0] CLS = 8'b1100_0011;
    localparam logic [EAw-1:0] SRC = 6'h2A;

    logic clk = 1'b0, reset;
    logic [EAw-1:0] src_e_addr, pck_dest;
    logic pck_req, pck_ack, data_valid, data_ready, flit_out_we, busy;
    logic [0:0] pck_class;
    logic [PSw-1:0] pck_size;
    logic [Fpay-1:0] data_in;
    logic [Fw-1:0] flit_out;
    logic [V-1:0] credit_in, man_credit;
    logic lb_en;

    ni_flit_injector #(
        .V(V), .B(B), .C(C), .Fpay(Fpay), .EAw(EAw), .CVw(8),
        .CLASS_SETTING(CLS), .MIN_PCK_SIZE(1), .PCK_SIZEw(PSw)
    ) dut (
        .clk(clk), .reset(reset), .src_e_addr(src_e_addr),
        .pck_req(pck_req), .pck_dest(pck_dest), .pck_class(pck_class),
        .pck_size(pck_size), .pck_ack(pck_ack), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .flit_out(flit_out),
        .flit_out_we(flit_out_we), .credit_in(credit_in), .busy(busy)
    );

    always #5 clk = ~clk;

    // Router model: optionally return a credit for every flit in the same cycle.
    assign credit_in = man_credit | ({V{lb_en & flit_out_we}} & flit_out[Fpay +: V]);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [Fw-1:0] flit; int at; } exp_t;
    exp_t sbq[$];
    int n_vec = 0, n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [Fw-1:0] mk_hdr(input logic [EAw-1:0] d, input logic c,
                                            input logic [V-1:0] vc, input logic tail);
        logic [Fpay-1:0] p;
        p = '0;
        p[EAw-1:0] = SRC;
        p[2*EAw-1:EAw] = d;
        p[2*EAw] = c;
        return {1'b1, tail, vc, p};
    endfunction

    always @(negedge clk) begin
        if (!reset && flit_out_we) begin
            if (sbq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected flit: got %0h expected none", flit_out);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("flit", flit_out, e.flit);
                check("flit cycle", cyc, e.at);
            end
        end
    end

    task automatic push(input logic [Fw-1:0] f);
        exp_t e;
        e.flit = f;
        e.at   = cyc + 1;
        sbq.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_hdr(input logic [EAw-1:0] d, input logic c, input logic [PSw-1:0] sz,
                          input logic [V-1:0] vc, input logic tail, input int exp_wait);
        int w = 0;
        bit got = 0;
        pck_req = 1; pck_dest = d; pck_class = c; pck_size = sz;
        while (!got && w < 30) begin
            #1;
            if (pck_ack) begin got = 1; push(mk_hdr(d, c, vc, tail)); end
            else w++;
            @(negedge clk);
        end
        pck_req = 0;
        if (!got) check("ack timeout", 0, 1);
        else if (exp_wait >= 0) check("ack wait", w, exp_wait);
    endtask

    task automatic do_beat(input logic [Fpay-1:0] d, input logic tail,
                           input logic [V-1:0] vc, input int exp_wait);
        int w = 0;
        bit got = 0;
        data_valid = 1; data_in = d;
        while (!got && w < 30) begin
            #1;
            if (data_ready) begin got = 1; push({1'b0, tail, vc, d}); end
            else w++;
            @(negedge clk);
        end
        data_valid = 0;
        if (!got) check("ready timeout", 0, 1);
        else if (exp_wait >= 0) check("ready wait", w, exp_wait);
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
    endtask

    task automatic credit_pulse(input logic [V-1:0] m);
        man_credit = m;
        @(negedge clk);
        man_credit = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; src_e_addr = SRC; pck_req = 1; pck_dest = '0; pck_class = '0;
        pck_size = '0; data_in = '0; data_valid = 0; man_credit = '0; lb_en = 0;
        @(negedge clk); #1;
        check("rst flit_out", flit_out, 0);
        check("rst flit_we", flit_out_we, 0);
        check("rst busy", busy, 0);
        check("rst pck_ack", pck_ack, 0);
        check("rst data_ready", data_ready, 0);
        pck_req = 0;
        @(negedge clk); reset = 0; @(negedge clk);

        // Basic 4-flit packet on VC0
        do_hdr(6'h15, 1'b0, 8'd4, 4'b0001, 1'b0, 0);
        #1 check("busy in body", busy, 1);
        do_beat(32'hA0, 1'b0, 4'b0001, 0);
        do_beat(32'hA1, 1'b0, 4'b0001, 0);
        do_beat(32'hA2, 1'b1, 4'b0001, 0);
        @(negedge clk); #1;
        check("busy after tail", busy, 0);
        check("flit_out held", flit_out, {1'b0, 1'b1, 4'b0001, 32'hA2});
        // Single-flit packets: VC0 is out of credit, so both land on VC1.
        @(negedge clk);
        data_valid = 1; data_in = 32'hDEAD;
        do_hdr(6'h05, 1'b0, 8'd1, 4'b0010, 1'b1, 0);
        data_valid = 1;
        #1 check("size1 no data", data_ready, 0);
        check("size1 idle", busy, 0);
        do_hdr(6'h06, 1'b0, 8'd1, 4'b0010, 1'b1, 0);
        data_valid = 0;
        repeat (2) @(negedge clk);

        // Credit exhaustion on VC0
        do_reset();
        do_hdr(6'h07, 1'b0, 8'd6, 4'b0001, 1'b0, 0);
        do_beat(32'hB0, 1'b0, 4'b0001, 0);
        do_beat(32'hB1, 1'b0, 4'b0001, 0);
        do_beat(32'hB2, 1'b0, 4'b0001, 0);
        data_valid = 1; data_in = 32'hB3;
        for (int k = 0; k < 3; k++) begin
            #1 check("stalled no credit", data_ready, 0);
            @(negedge clk);
        end
        man_credit = 4'b0001;
        #1 check("ready before credit lands", data_ready, 0);
        @(negedge clk); man_credit = '0;
        do_beat(32'hB3, 1'b0, 4'b0001, 0);
        data_valid = 1; data_in = 32'hB4;
        #1 check("one credit one flit", data_ready, 0);
        @(negedge clk);
        credit_pulse(4'b0001);
        do_beat(32'hB4, 1'b1, 4'b0001, 0);
        repeat (2) @(negedge clk);

        // Send and credit in the same cycle keep the counter steady
        do_reset();
        lb_en = 1;
        do_hdr(6'h33, 1'b0, 8'd12, 4'b0001, 1'b0, 0);
        for (int k = 0; k < 11; k++)
            do_beat(32'hC00 + 32'(k), k == 10, 4'b0001, 0);
        @(negedge clk); lb_en = 0;
        repeat (2) @(negedge clk);

        // Class 1 restricted to VCs 2/3, alternating
        do_reset();
        do_hdr(6'h01, 1'b1, 8'd2, 4'b0100, 1'b0, 0);
        do_beat(32'hD0, 1'b1, 4'b0100, 0);
        do_hdr(6'h02, 1'b1, 8'd2, 4'b1000, 1'b0, 0);
        do_beat(32'hD1, 1'b1, 4'b1000, 0);
        repeat (2) @(negedge clk);

        // Reset in the middle of a body
        do_reset();
        do_hdr(6'h3F, 1'b0, 8'd5, 4'b0001, 1'b0, 0);
        do_beat(32'hE0, 1'b0, 4'b0001, 0);
        data_valid = 1; data_in = 32'hE1;
        #2 reset = 1;
        #1;
        check("midrst flit_out", flit_out, 0);
        check("midrst flit_we", flit_out_we, 0);
        check("midrst busy", busy, 0);
        check("midrst data_ready", data_ready, 0);
        check("midrst pck_ack", pck_ack, 0);
        @(negedge clk); reset = 0; data_valid = 0;
        @(negedge clk);
        do_hdr(6'h10, 1'b0, 8'd4, 4'b0001, 1'b0, 0);
        do_beat(32'hF0, 1'b0, 4'b0001, 0);
        do_beat(32'hF1, 1'b0, 4'b0001, 0);
        do_beat(32'hF2, 1'b1, 4'b0001, 0);
        repeat (3) @(negedge clk);

        check("scoreboard drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ni_flit_injector.md
Name: ni_flit_injector

Overview:
- Network-interface transmitter that drives one router input port: flit_in_all slice, flit_in_we_all bit and credit_out_all VC slice.
- Segments core packet requests into header/body/tail flits and selects an output VC per packet (class-restricted, round-robin among VCs with credit).
- Tracks per-VC downstream buffer credits.
- Sits between an endpoint core and the local port of a router.

Parameters:
- V, 4, VCs per port.
- B, 4, flit buffer depth per VC at the router input; initial credit per VC.
- C, 2, number of message classes; 0 means classless.
- Fpay, 32, flit payload width.
- EAw, 6, endpoint address width.
- CVw, (C==0)?V:C*V, width of class-to-VC map.
- CLASS_SETTING, {CVw{1'b1}}, bits [c*V +: V] give the VCs class c may use.
- MIN_PCK_SIZE, 2, minimum packet size in flits (>=1).
- PCK_SIZEw, 8, width of the packet-size field.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- src_e_addr  in  EAw  own endpoint address, static
- pck_req  in  1  core requests a new packet
- pck_dest  in  EAw  destination endpoint
- pck_class  in  max(1,log2C)  message class
- pck_size  in  PCK_SIZEw  total flits including header
- pck_ack  out  1  request accepted (combinational, one cycle)
- data_in  in  Fpay  body/tail payload word
- data_valid  in  1  data_in valid
- data_ready  out  1  data_in consumed this cycle (combinational)
- flit_out  out  2+V+Fpay  flit to router port
- flit_out_we  out  1  flit write enable
- credit_in  in  V  one-hot per-VC credit return from router
- busy  out  1  packet in progress

Behaviour:
- Flit format, MSB first: hdr_flag, tail_flag, V-bit one-hot VC, Fpay payload.
- Header payload layout: [EAw-1:0]=src, [2EAw-1:EAw]=dest, next Cw bits=class, rest zero.
- Credit counters:
  - One per VC, width log2(B+1), reset to B.
  - Decrement on flit_out_we for that VC; increment on credit_in bit.
  - Both in the same cycle leave the counter unchanged.
  - Credit at count==B, or a send at count==0, is an error: simulation-only $display with time and VC; counter saturates.
- Eligible VC: CLASS_SETTING bit set for pck_class AND counter>0 after the current cycle's decrement.
- FSM states: IDLE, BODY.
  - IDLE with pck_req and >=1 eligible VC:
    - pck_ack=1 combinationally.
    - Round-robin arbiter picks a VC; pointer advances past the winner.
    - dest, class, size and vc are latched.
    - Header registered onto flit_out with flit_out_we=1 next cycle (latency 1).
    - tail_flag=1 iff pck_size==1; then remain IDLE, otherwise go to BODY.
  - IDLE with no eligible VC: pck_ack=0, wait.
  - pck_size<MIN_PCK_SIZE or 0: accepted, treated as MIN_PCK_SIZE, simulation warning.
  - BODY:
    - data_ready = data_valid-independent (credit[vc]>0).
    - Beat sent when data_valid && data_ready: flit with hdr=0, payload=data_in, latched VC; it appears the next cycle.
    - Remaining-flit counter decrements per beat.
    - Last beat sets tail_flag=1 and returns to IDLE.
    - A new pck_req is not serviced in the same cycle as the tail beat.
- Outputs:
  - flit_out_we is high only in the cycle after an accepted header or beat; flit_out holds its last value otherwise.
  - busy = (state==BODY).
- Reset (any time, including mid-packet): state IDLE; all credits B; RR pointer 0; flit_out=0, flit_out_we=0, pck_ack=0, data_ready=0, busy=0. A partial packet is abandoned.
- One VC per packet: all flits of a packet use the VC selected at header time.

Decomposition:
- Shared package: flit field offsets (HDR_BIT, TAIL_BIT, VC_LSB, Fw=2+V+Fpay), header address/class offsets, Cw function, log2 function.
- One sub-module: ni_vc_credit_cnt. It is V counters with eligibility mask output, reset to B, with overflow/underflow checks.
- Round-robin arbitration reuses the existing arbiter.

Test Plan:
- After reset, pck_req with dest=0x15, class 0, size 4, data words 0xA0..0xA2 always valid:
  - pck_ack at cycle 0.
  - Flits on cycles 1-4: header VC 0001 with payload dest 0x15 / src; bodies 0xA0, 0xA1; tail 0xA2 with tail_flag.
  - credit[0] ends at 0.
- Credit exhaustion: no credit_in, size 6 on VC0 (B=4):
  - Header plus 3 bodies sent, then data_ready=0.
  - One credit_in[0] pulse gives exactly one more flit.
- Simultaneous send and credit_in on the same VC for 10 cycles → counter constant, no error message.
- CLASS_SETTING=8'b1100_0011, class 1 request → header VC one-hot is 0100 or 1000 only; two back-to-back class-1 packets alternate VCs 2 and 3.
- MIN_PCK_SIZE=1, size 1 → single flit with hdr=1, tail=1, no data consumed, FSM stays IDLE.
- Assert reset mid-BODY (after 2 of 5 flits) → outputs 0 immediately; after release all credits=4 and a new packet starts on VC0.
